// File: rtl/sm_hex_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sm_hex_scanner
// Description : Multiplexed 7-segment scan driver for a common-anode display.
//               Shows a 4*DIGITS-bit word as hex digits. The word is latched
//               once per scan frame, and each digit slot starts with a short
//               blank period that suppresses ghosting.
//               Optional build macro SM_HEX_LZB_EN turns on leading-zero
//               blanking; the default build shows every digit.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               en       - display enable (0 forces all anodes off)
//               value    - word to display, digit d = value[4d+3:4d]
//               dp       - per-digit decimal point request, active-high
//               anode_n  - digit select, active-low
//               seg_n    - segments {g,f,e,d,c,b,a}, active-low
//               dp_n     - decimal point segment, active-low
//               frame    - one-cycle pulse on each shadow load
// Revision    : 1.0 - initial release
// ============================================================================
module sm_hex_scanner #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 10,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     anode_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

    // Scan state
    logic [SCAN_DIV-1:0]  cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [4*DIGITS-1:0]  shadow_q;
    logic [DIGITS-1:0]    shadow_dp_q;

    // Registered outputs and their next-state values
    logic [DIGITS-1:0]    anode_n_q, anode_n_d;
    logic [6:0]           seg_n_q,   seg_n_d;
    logic                 dp_n_q,    dp_n_d;
    logic                 frame_q;

    logic                 w_slot_end;
    logic                 w_frame_start;
    logic                 w_guard;
    logic [3:0]           w_nib;
    logic                 w_sdp;
    logic [DIGITS-1:0]    w_anode_on;

`ifdef SM_HEX_LZB_EN
    logic [DIGITS-1:0]    lz_mask_q, lz_mask_d;
    logic                 w_lz;
    logic                 w_zero_run;
`endif

    // Active-low 7-segment encoding of one hex nibble, bit order {g..a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_slot_end    = &cnt_q;
    assign w_frame_start = (idx_q == '0) && (cnt_q == '0);
    assign w_anode_on    = ~(DIGITS'(1) << idx_q);

    // A zero-length guard would make the compare constant-false, so it is
    // elaborated away entirely in that case.
    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            localparam logic [SCAN_DIV-1:0] GUARD_LIM = SCAN_DIV'(GUARD_CYCLES);
            assign w_guard = (cnt_q < GUARD_LIM);
        end
    endgenerate

    // Select the shadow nibble / dp bit for the current digit. Indices at or
    // above DIGITS are unreachable and fall back to the defaults.
    always_comb begin
        w_nib = 4'h0;
        w_sdp = 1'b0;
`ifdef SM_HEX_LZB_EN
        w_lz  = 1'b0;
`endif
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                w_nib = shadow_q[4*d +: 4];
                w_sdp = shadow_dp_q[d];
`ifdef SM_HEX_LZB_EN
                w_lz  = lz_mask_q[d];
`endif
            end
        end
    end

`ifdef SM_HEX_LZB_EN
    // Walk down from the top digit; a digit is a leading zero while every
    // nibble from it upward is zero. Digit 0 is never blanked.
    always_comb begin
        lz_mask_d  = '0;
        w_zero_run = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_zero_run   = w_zero_run & (value[4*d +: 4] == 4'h0);
            lz_mask_d[d] = w_zero_run;
        end
    end
`endif

    // Next output values, registered below for a one-cycle latency
    always_comb begin
        anode_n_d = '1;
        seg_n_d   = 7'h7F;
        dp_n_d    = 1'b1;
        if (en && !w_guard) begin
`ifdef SM_HEX_LZB_EN
            if (w_lz) begin
                // Blanked leading zero still lights its decimal point
                if (w_sdp) begin
                    anode_n_d = w_anode_on;
                    dp_n_d    = 1'b0;
                end
            end else begin
                anode_n_d = w_anode_on;
                seg_n_d   = hex7(w_nib);
                dp_n_d    = ~w_sdp;
            end
`else
            anode_n_d = w_anode_on;
            seg_n_d   = hex7(w_nib);
            dp_n_d    = ~w_sdp;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            anode_n_q   <= '1;
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
            frame_q     <= 1'b0;
`ifdef SM_HEX_LZB_EN
            lz_mask_q   <= '0;
`endif
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (w_slot_end) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
            frame_q <= w_frame_start;
            if (w_frame_start) begin
                shadow_q    <= value;
                shadow_dp_q <= dp;
`ifdef SM_HEX_LZB_EN
                lz_mask_q   <= lz_mask_d;
`endif
            end
            anode_n_q <= anode_n_d;
            seg_n_q   <= seg_n_d;
            dp_n_q    <= dp_n_d;
        end
    end

    assign anode_n = anode_n_q;
    assign seg_n   = seg_n_q;
    assign dp_n    = dp_n_q;
    assign frame   = frame_q;

endmodule
`default_nettype wire
